// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between DSP clients and the shared-multiplier arbiter.
// Clients drive requests through the master modport; the arbiter uses the slave modport.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_z;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_z
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one 8x8 unsigned carry-save multiplier among NUM_REQ requesters.
// Accepted operands are registered, multiplied, and returned one-hot tagged two cycles later.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int OPCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    mult_share_arbiter_if.slave bus,
    output logic                busy_o,
    output logic [OPCNT_W-1:0]  op_count_o
);
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic               accept;
    logic [7:0]         a_sel, b_sel;

    logic [7:0]         s1_a_q, s1_b_q;
    logic [NUM_REQ-1:0] s1_tag_q;
    logic               s1_v_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [15:0]        rsp_z_q;
    logic [OPCNT_W-1:0] op_count_q;

    logic [15:0]        pp [8];
    logic [15:0]        csa_sum, csa_car, csa_tmp, product;

    // Search from ptr upward with explicit wrap so non-power-of-two NUM_REQ works.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!grant_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant_oh[gi] = rst_n & en_i & grant_found & (grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign accept = |grant_oh;
    assign a_sel  = bus.req_a[{grant_idx, 3'b000} +: 8];
    assign b_sel  = bus.req_b[{grant_idx, 3'b000} +: 8];

    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = s1_b_q[gi] ? ({8'd0, s1_a_q} << gi) : 16'd0;
        end
    endgenerate

    // 3:2 compression of the partial products down to sum/carry, then one final add.
    // Bits carried past bit 15 are dropped safely: the true product is below 2^16.
    always_comb begin
        csa_sum = pp[0];
        csa_car = pp[1];
        csa_tmp = '0;
        for (int r = 2; r < 8; r++) begin
            csa_tmp = csa_sum ^ csa_car ^ pp[r];
            csa_car = ((csa_sum & csa_car) | (csa_sum & pp[r]) | (csa_car & pp[r])) << 1;
            csa_sum = csa_tmp;
        end
        product = csa_sum + csa_car;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s1_v_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            s1_v_q <= accept;
            if (accept) begin
                s1_a_q   <= a_sel;
                s1_b_q   <= b_sel;
                s1_tag_q <= grant_oh;
            end
            rsp_valid_q <= s1_v_q ? s1_tag_q : '0;
            if (s1_v_q)
                rsp_z_q <= product;
            if (accept && op_count_q != '1)
                op_count_q <= op_count_q + 1'b1;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign busy_o        = s1_v_q | (|rsp_valid_q);
    assign op_count_o    = op_count_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, hand sequences, random traffic
// against a queue-based reference model, and a saturation run on a 4-bit counter instance.
module tb_mult_share_arbiter;
    localparam int N = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        en_s  = 1'b0;
    logic        busy, busy_s;
    logic [15:0] op_count;
    logic [3:0]  op_count_s;

    mult_share_arbiter_if #(.NUM_REQ(N)) bus ();
    mult_share_arbiter_if #(.NUM_REQ(N)) bus_s ();

    mult_share_arbiter #(.NUM_REQ(N), .IDX_W(2), .OPCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .bus(bus.slave),
        .busy_o(busy), .op_count_o(op_count)
    );

    mult_share_arbiter #(.NUM_REQ(N), .IDX_W(2), .OPCNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en_i(en_s), .bus(bus_s.slave),
        .busy_o(busy_s), .op_count_o(op_count_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: rotating priority pointer, saturating count, queue of due responses.
    typedef struct {
        int idx;
        int z;
        int due;
    } rsp_t;
    rsp_t pend[$];
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   cyc   = 0;
    int   last_grant = -1;

    typedef struct {
        int idx;
        int a;
        int b;
        int z;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (!rst_n || !en) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Compare every output against the model mid-cycle, then advance one clock.
    task automatic tick();
        int g, exp_tag, exp_z, za;
        bit exp_busy;
        @(negedge clk);
        g = model_grant();
        chk("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        exp_tag = 0; exp_z = 0; exp_busy = 0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                exp_tag = 1 << pend[i].idx;
                exp_z   = pend[i].z;
            end
            if (pend[i].due == cyc || pend[i].due == cyc + 1) exp_busy = 1;
        end
        chk("rsp_valid", bus.rsp_valid, exp_tag);
        if (exp_tag != 0) chk("rsp_z", bus.rsp_z, exp_z);
        chk("busy", busy, exp_busy);
        chk("op_count", op_count, m_cnt);
        za = (g >= 0) ? int'(bus.req_a[g*8 +: 8]) * int'(bus.req_b[g*8 +: 8]) : 0;
        last_grant = g;
        @(posedge clk);
        if (g >= 0) begin
            pend.push_back('{idx: g, z: za, due: cyc + 2});
            m_ptr = (g + 1) % N;
            if (m_cnt < 65535) m_cnt++;
        end
        cyc++;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1;
        bus.req_valid = '1;
        model_reset();
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_z", bus.rsp_z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        en = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    vec_t vt[8];
    int   rr_exp[3];
    int   pulses;

    initial begin
        bus.req_valid   = '0; bus.req_a   = '0; bus.req_b   = '0;
        bus_s.req_valid = '0; bus_s.req_a = '0; bus_s.req_b = '0;
        vt[0] = '{idx: 0, a: 3,   b: 5,   z: 15};
        vt[1] = '{idx: 2, a: 255, b: 255, z: 65025};
        vt[2] = '{idx: 1, a: 0,   b: 255, z: 0};
        vt[3] = '{idx: 3, a: 1,   b: 255, z: 255};
        vt[4] = '{idx: 0, a: 128, b: 128, z: 16384};
        vt[5] = '{idx: 1, a: 255, b: 1,   z: 255};
        vt[6] = '{idx: 2, a: 128, b: 255, z: 32640};
        vt[7] = '{idx: 3, a: 0,   b: 0,   z: 0};
        #2;
        do_reset();

        // Single-op vectors: grant, product and tag two cycles after the accept.
        en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            bus.req_valid = 4'(1 << vt[v].idx);
            bus.req_a[vt[v].idx*8 +: 8] = 8'(vt[v].a);
            bus.req_b[vt[v].idx*8 +: 8] = 8'(vt[v].b);
            #1;
            chk("vec_ready", bus.req_ready, 1 << vt[v].idx);
            tick();
            bus.req_valid = '0;
            tick();
            chk("vec_rsp_valid", bus.rsp_valid, 1 << vt[v].idx);
            chk("vec_rsp_z", bus.rsp_z, vt[v].z);
            if (v == 0) chk("vec_op_count_first", op_count, 1);
            tick();
        end

        // All requesters valid: strict rotation from ptr=0.
        do_reset();
        en = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*8 +: 8] = rand_operand();
            bus.req_b[i*8 +: 8] = rand_operand();
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_all_grant", bus.req_ready, 1 << (k % N));
            tick();
            bus.req_a[last_grant*8 +: 8] = rand_operand();
            bus.req_b[last_grant*8 +: 8] = rand_operand();
        end
        bus.req_valid = '0;
        repeat (3) tick();

        // Sparse requesters 1 and 3 starting from ptr=2.
        do_reset();
        en = 1'b1;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1010;
        rr_exp[0] = 4'b1000; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_sparse_grant", bus.req_ready, rr_exp[k]);
            tick();
        end
        bus.req_valid = '0;
        repeat (3) tick();

        // en falls with two ops in flight.
        bus.req_valid = 4'b0011;
        tick();
        tick();
        en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.rsp_valid != 0) pulses++;
            tick();
        end
        chk("en_off_pulses", pulses, 2);
        chk("en_off_busy_fell", busy, 0);
        bus.req_valid = '0;

        // Reset one cycle after an accept discards the op and the pointer.
        en = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_a[16 +: 8] = 8'd7;
        bus.req_b[16 +: 8] = 8'd9;
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_rsp_z", bus.rsp_z, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        bus.req_valid = '1;
        #1;
        chk("midrst_ptr_zero", bus.req_ready, 1);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // Random traffic; a requester holds its request until granted.
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || last_grant == i) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    bus.req_a[i*8 +: 8] = rand_operand();
                    bus.req_b[i*8 +: 8] = rand_operand();
                end
            end
            tick();
        end
        bus.req_valid = '0;
        repeat (3) tick();

        // Saturating counter on the OPCNT_W=4 instance.
        en_s = 1'b1;
        bus_s.req_valid = 4'b0001;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sat_count_10", op_count_s, 10);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("sat_count_20", op_count_s, 15);
        bus_s.req_valid = '0;
        en_s = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
